// File: rtl/jk_drive_pkg.sv
// jk_drive_pkg
// Shared definitions for the J/K drive controller: the command opcodes, the
// controller FSM states and the J/K excitation pairs presented to the
// flip-flop.
package jk_drive_pkg;

  // Command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SETTLE = 2'b10,
    CHECK  = 2'b11
  } state_e;

  // {j, k} excitation pairs.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Excitation that a DRIVE cycle presents for a given command.
  function automatic logic [1:0] op_excitation(input op_e op);
    logic [1:0] jk;
    unique case (op)
      OP_HOLD:  jk = JK_HOLD;
      OP_CLEAR: jk = JK_CLR;
      OP_SET:   jk = JK_SET;
      default:  jk = JK_TGL;
    endcase
    return jk;
  endfunction

  // HOLD_N and TOGGLE_N run for a programmed number of cycles.
  function automatic logic is_count_op(input op_e op);
    return (op == OP_HOLD) || (op == OP_TOGGLE);
  endfunction

endpackage

// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl
// Command sequencer in front of a JK flip-flop. Accepts HOLD_N / CLEAR / SET /
// TOGGLE_N commands on a valid/ready handshake, drives registered j/k for the
// required number of cycles, lets the flip-flop settle, then compares its q
// against the expected final value. SET/CLEAR are re-driven up to MAX_RETRY
// times on a mismatch; counted ops are never retried.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted (IDLE, and no done/err pulse showing)
//   cmd_op     00 HOLD_N, 01 CLEAR, 10 SET, 11 TOGGLE_N
//   cmd_cnt    cycle count for HOLD_N / TOGGLE_N
//   q_fb       flip-flop q read back
//   j, k       registered excitation to the flip-flop
//   busy       high in any state other than IDLE
//   done       one-cycle pulse: command completed and verified
//   err        one-cycle pulse: verification failed, retries exhausted
module jk_drive_ctrl
  import jk_drive_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       retry_q;
  logic             exp_q;
  logic [1:0]       jk_q;
  logic             done_q;
  logic             err_q;

  logic accept;
  op_e  op_d;
  logic exp_d;

  assign accept = cmd_valid && cmd_ready;
  assign op_d   = op_e'(cmd_op);

  // Expected final q, fixed at accept time from the q snapshot.
  always_comb begin
    exp_d = 1'b0;
    unique case (op_d)
      OP_SET:   exp_d = 1'b1;
      OP_CLEAR: exp_d = 1'b0;
      OP_HOLD:  exp_d = q_fb;
      default:  exp_d = q_fb ^ cmd_cnt[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      exp_q   <= 1'b0;
      jk_q    <= JK_HOLD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // j/k are only non-zero while DRIVE; pulses last one cycle.
      jk_q   <= JK_HOLD;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_d;
            cnt_q   <= cmd_cnt;
            retry_q <= '0;
            exp_q   <= exp_d;
            if (is_count_op(op_d) && (cmd_cnt == '0)) begin
              // Zero-length counted op: nothing to drive.
              state_q <= SETTLE;
            end else begin
              state_q <= DRIVE;
              jk_q    <= op_excitation(op_d);
            end
          end
        end
        DRIVE: begin
          // cnt_q holds the DRIVE cycles still to go including this one.
          if (is_count_op(op_q) && (cnt_q > CNT_W'(1))) begin
            cnt_q <= cnt_q - CNT_W'(1);
            jk_q  <= op_excitation(op_q);
          end else begin
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (q_fb == exp_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (!is_count_op(op_q) && (retry_q < 2'(MAX_RETRY))) begin
            retry_q <= retry_q + 2'd1;
            state_q <= DRIVE;
            jk_q    <= op_excitation(op_q);
          end else begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is held off while the done/err pulse is showing so a new accept
  // never coincides with the completion pulse of the previous command.
  assign cmd_ready = (state_q == IDLE) && !done_q && !err_q;
  assign busy      = (state_q != IDLE);
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
module tb_jk_drive_ctrl;

  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_cnt = 4'd0;
  logic       q_fb;
  logic       j, k, busy, done, err;

  // flip-flop under control, with a bench-side preload and a fault override
  logic ff_q;
  logic ff_load = 1'b0;
  logic ff_load_val = 1'b0;
  logic fault_en = 1'b0;
  logic fault_val = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ff_load) ff_q <= ff_load_val;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = fault_en ? fault_val : ff_q;

  jk_drive_ctrl #(.CNT_W(4), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;

  // expected output vector per cycle: {j, k, busy, ready, done, err}
  typedef struct packed {
    logic j, k, busy, ready, done, err;
  } exp_t;

  localparam exp_t IDLE_EXP = '{j:1'b0, k:1'b0, busy:1'b0, ready:1'b1, done:1'b0, err:1'b0};

  exp_t expq[$];
  logic model_q;
  logic chk_en = 1'b0;

  // Transaction-level model: lists the visible cycles a command produces,
  // starting with the cycle in which it is presented.
  task automatic plan(input logic [1:0] op, input logic [3:0] cnt);
    logic q0, expv, obs;
    int   tries, n;
    logic setclr;
    setclr = (op == 2'b10) || (op == 2'b01);
    q0 = fault_en ? fault_val : model_q;
    case (op)
      2'b10:   expv = 1'b1;
      2'b01:   expv = 1'b0;
      2'b00:   expv = q0;
      default: expv = q0 ^ cnt[0];
    endcase
    expq.push_back(IDLE_EXP);
    tries = setclr ? 1 + MAX_RETRY : 1;
    for (int a = 0; a < tries; a++) begin
      n = setclr ? 1 : int'(cnt);
      for (int i = 0; i < n; i++) begin
        expq.push_back('{j:op[1], k:op[0], busy:1'b1, ready:1'b0, done:1'b0, err:1'b0});
        case (op)
          2'b10:   model_q = 1'b1;
          2'b01:   model_q = 1'b0;
          2'b11:   model_q = ~model_q;
          default: model_q = model_q;
        endcase
      end
      expq.push_back('{j:1'b0, k:1'b0, busy:1'b1, ready:1'b0, done:1'b0, err:1'b0});
      expq.push_back('{j:1'b0, k:1'b0, busy:1'b1, ready:1'b0, done:1'b0, err:1'b0});
      obs = fault_en ? fault_val : model_q;
      if (obs == expv) begin
        expq.push_back('{j:1'b0, k:1'b0, busy:1'b0, ready:1'b0, done:1'b1, err:1'b0});
        return;
      end
    end
    expq.push_back('{j:1'b0, k:1'b0, busy:1'b0, ready:1'b0, done:1'b0, err:1'b1});
  endtask

  // cycle-by-cycle compare against the model
  int cyc = 0;
  always @(negedge clk) begin
    exp_t e, a;
    if (chk_en) begin
      e = (expq.size() != 0) ? expq.pop_front() : IDLE_EXP;
      a = '{j:j, k:k, busy:busy, ready:cmd_ready, done:done, err:err};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_outputs cyc=%0d {j,k,busy,ready,done,err} got %b want %b", cyc, a, e);
      end
    end
  end

  // event monitor
  int acc_cyc = 0, prev_acc = 0, nacc = 0;
  int ndone = 0, nerr = 0, nj = 0, nk = 0;
  int done_lat = -1, err_lat = -1;
  always @(posedge clk) begin
    cyc++;
    if (!rst && cmd_valid && cmd_ready) begin
      prev_acc = acc_cyc;
      acc_cyc = cyc;
      nacc++;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin ndone++; done_lat = cyc - acc_cyc; end
      if (err)  begin nerr++;  err_lat  = cyc - acc_cyc; end
      if (j === 1'b1) nj++;
      if (k === 1'b1) nk++;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic v);
    ff_load = 1'b1;
    ff_load_val = v;
    tick();
    ff_load = 1'b0;
    model_q = v;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (expq.size() != 0 && i < 200) begin
      tick();
      i++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending cycles want 0", name, expq.size());
      expq.delete();
    end
    tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] cnt, input string name);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_cnt = cnt;
    plan(op, cnt);
    tick();
    cmd_valid = 1'b0;
    drain(name);
  endtask

  int d0, e0, j0, k0, a0;
  task automatic snap();
    d0 = ndone; e0 = nerr; j0 = nj; k0 = nk; a0 = nacc;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_jk", int'({j, k}), 0);
    check("reset_done_err", int'({done, err}), 0);
    chk_en = 1'b1;

    // SET from q=0
    set_q(1'b0);
    snap();
    issue(2'b10, 4'd0, "set");
    $display("txn SET q0=0 q=%0d lat=%0d", ff_q, done_lat);
    check("set_lat", done_lat, 3);
    check("set_jpulses", nj - j0, 1);
    check("set_kpulses", nk - k0, 0);
    check("set_q", int'(ff_q), 1);
    check("set_err", nerr - e0, 0);

    // TOGGLE_N cnt=5 from q=1
    set_q(1'b1);
    snap();
    issue(2'b11, 4'd5, "tgl5");
    $display("txn TOGGLE cnt=5 q0=1 q=%0d lat=%0d", ff_q, done_lat);
    check("tgl5_lat", done_lat, 7);
    check("tgl5_jpulses", nj - j0, 5);
    check("tgl5_q", int'(ff_q), 0);

    // TOGGLE_N cnt=4 from q=0
    set_q(1'b0);
    issue(2'b11, 4'd4, "tgl4");
    $display("txn TOGGLE cnt=4 q0=0 q=%0d lat=%0d", ff_q, done_lat);
    check("tgl4_lat", done_lat, 6);
    check("tgl4_q", int'(ff_q), 0);

    // HOLD_N cnt=0
    snap();
    issue(2'b00, 4'd0, "hold0");
    $display("txn HOLD cnt=0 q0=0 q=%0d lat=%0d", ff_q, done_lat);
    check("hold0_lat", done_lat, 2);
    check("hold0_jk_pulses", (nj - j0) + (nk - k0), 0);
    check("hold0_q", int'(ff_q), 0);

    // CLEAR from 1, then TOGGLE_N at the maximum count
    set_q(1'b1);
    issue(2'b01, 4'd9, "clear");
    $display("txn CLEAR q0=1 q=%0d lat=%0d", ff_q, done_lat);
    check("clear_q", int'(ff_q), 0);
    check("clear_lat", done_lat, 3);
    issue(2'b11, 4'd15, "tgl15");
    $display("txn TOGGLE cnt=15 q0=0 q=%0d lat=%0d", ff_q, done_lat);
    check("tgl15_q", int'(ff_q), 1);
    check("tgl15_lat", done_lat, 17);

    // SET with q_fb stuck at 0: retries exhausted
    set_q(1'b0);
    fault_en = 1'b1;
    fault_val = 1'b0;
    snap();
    issue(2'b10, 4'd0, "fault_set");
    $display("txn SET stuck0 jpulses=%0d err=%0d done=%0d", nj - j0, nerr - e0, ndone - d0);
    check("fault_jpulses", nj - j0, 3);
    check("fault_err", nerr - e0, 1);
    check("fault_done", ndone - d0, 0);
    check("fault_err_lat", err_lat, 9);
    fault_en = 1'b0;

    // back-to-back CLEAR then SET with cmd_valid held
    set_q(1'b1);
    snap();
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_cnt = 4'd0;
    plan(2'b01, 4'd0);
    tick();
    cmd_op = 2'b10;
    plan(2'b10, 4'd0);
    repeat (5) tick();
    cmd_valid = 1'b0;
    drain("b2b");
    $display("txn CLEAR+SET b2b accepts=%0d gap=%0d q=%0d", nacc - a0, acc_cyc - prev_acc, ff_q);
    check("b2b_accepts", nacc - a0, 2);
    check("b2b_gap", acc_cyc - prev_acc, 5);
    check("b2b_done", ndone - d0, 2);
    check("b2b_q", int'(ff_q), 1);

    // reset during the 3rd DRIVE cycle of TOGGLE_N cnt=8
    set_q(1'b0);
    snap();
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_cnt = 4'd8;
    plan(2'b11, 4'd8);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    while (expq.size() > 1) void'(expq.pop_back());
    tick();
    rst = 1'b0;
    check("rst_jk", int'({j, k}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    repeat (12) tick();
    $display("txn TOGGLE cnt=8 aborted done=%0d err=%0d q=%0d", ndone - d0, nerr - e0, ff_q);
    check("rst_no_done", ndone - d0, 0);
    check("rst_no_err", nerr - e0, 0);
    check("rst_q_three_toggles", int'(ff_q), 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
